// File: rtl/uproc_pkg.sv
// uproc_pkg: shared widths, reset PC and fetch-stage types for the uProcessor core
package uproc_pkg;
  localparam int ADDR_W = 8;
  localparam int INSTR_W = 16;
  localparam int QDEPTH = 2;
  localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;
  typedef enum logic [1:0] {FETCH, WAIT, DISCARD} fetch_state_t;
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fq_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: circular prefetch buffer with flush; head is driven from storage registers only
module fetch_queue #(
  parameter int W = 24,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     nReset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [W-1:0]             data_i,
  output logic [W-1:0]             head_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [PW:0] count_q;
  assign head_o = mem_q[rd_q];
  assign count_o = count_q;
  always_ff @(posedge clk or negedge nReset)
    if (!nReset) begin
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
    end else begin
      if (push_i) mem_q[wr_q] <= data_i;
      wr_q <= wr_q + PW'(push_i);
      rd_q <= rd_q + PW'(pop_i);
      count_q <= count_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
    end
  // the fetch FSM only requests when space is guaranteed, so a push into a full queue is a bug
  always_ff @(posedge clk)
    if (nReset && !flush_i) assert (!(push_i && !pop_i && count_q == (PW+1)'(DEPTH)));
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, fetch FSM and memory handshake feeding the decoder through a prefetch queue
module fetch_unit #(
  parameter int ADDR_W = uproc_pkg::ADDR_W,
  parameter int INSTR_W = uproc_pkg::INSTR_W,
  parameter int QDEPTH = uproc_pkg::QDEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(uproc_pkg::RESET_PC)
) (
  input  logic               clk,
  input  logic               nReset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc
);
  import uproc_pkg::*;
  localparam int CW = $clog2(QDEPTH) + 1;
  fetch_state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, old_q, old_d;
  logic started_q, acc, pop, push;
  logic [CW-1:0] count;
  logic [INSTR_W+ADDR_W-1:0] head;
  assign imem_req = started_q && state_q != WAIT;
  // DISCARD keeps presenting the abandoned address until memory completes it
  assign imem_addr = state_q == DISCARD ? old_q : pc_q;
  assign acc = imem_req && imem_ack;
  assign instr_valid = count != '0;
  assign pop = instr_valid && instr_ready;
  assign push = acc && state_q == FETCH && !redirect;
  assign {instr, instr_pc} = head;
  always_comb begin
    pc_d = redirect ? redirect_pc : push ? pc_q + ADDR_W'(1) : pc_q;
    old_d = (redirect && state_q == FETCH) ? pc_q : old_q;
    state_d = redirect ? ((imem_req && !imem_ack) ? DISCARD : FETCH)
            : state_q == FETCH ? ((acc && !pop && count == CW'(QDEPTH-1)) ? WAIT : FETCH)
            : state_q == WAIT ? (pop ? FETCH : WAIT)
            : (acc ? FETCH : DISCARD);
  end
  always_ff @(posedge clk or negedge nReset)
    if (!nReset) begin
      started_q <= 1'b0;
      state_q <= FETCH;
      pc_q <= RESET_PC;
      old_q <= RESET_PC;
    end else begin
      started_q <= 1'b1;
      state_q <= state_d;
      pc_q <= pc_d;
      old_q <= old_d;
    end
  fetch_queue #(.W(INSTR_W+ADDR_W), .DEPTH(QDEPTH)) u_queue (
    .clk     (clk),
    .nReset  (nReset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect),
    .data_i  ({imem_rdata, imem_addr}),
    .head_o  (head),
    .count_o (count)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit handshake, back-pressure, redirect, wrap and reset
module tb_fetch_unit;
  logic clk = 1'b0;
  logic nReset = 1'b0;
  logic imem_req, imem_ack, instr_valid, instr_ready, redirect;
  logic [7:0] imem_addr, instr_pc, redirect_pc;
  logic [15:0] imem_rdata, instr;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  assign imem_rdata = 16'hC000 | {8'h00, imem_addr};
  fetch_unit dut (
    .clk         (clk),
    .nReset      (nReset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check_reset(input string tag);
    chk({tag, "_req"}, imem_req, 0);
    chk({tag, "_addr"}, imem_addr, 8'h00);
    chk({tag, "_instr"}, instr, 0);
    chk({tag, "_ipc"}, instr_pc, 0);
    chk({tag, "_valid"}, instr_valid, 0);
  endtask
  task automatic do_reset();
    nReset = 1'b0;
    redirect = 1'b0;
    redirect_pc = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_reset("rst");
    @(negedge clk);
    nReset = 1'b1;
  endtask
  initial begin
    imem_ack = 1'b1;
    instr_ready = 1'b1;
    redirect = 1'b0;
    redirect_pc = 8'h00;
    // streaming with zero-wait memory and an always-ready decoder
    do_reset();
    step();
    chk("s_req_e1", imem_req, 1);
    chk("s_addr_e1", imem_addr, 8'h00);
    chk("s_valid_e1", instr_valid, 0);
    for (int k = 2; k <= 5; k++) begin
      step();
      chk("s_addr", imem_addr, k - 1);
      chk("s_valid", instr_valid, 1);
      chk("s_ipc", instr_pc, k - 2);
      chk("s_instr", instr, 32'hC000 | (k - 2));
    end
    // decoder stalled: two words fill the queue, then requests stop
    instr_ready = 1'b0;
    do_reset();
    step();
    chk("bp_addr_e1", imem_addr, 8'h00);
    step();
    chk("bp_req_e2", imem_req, 1);
    chk("bp_addr_e2", imem_addr, 8'h01);
    chk("bp_ipc_e2", instr_pc, 8'h00);
    step();
    chk("bp_req_e3", imem_req, 0);
    chk("bp_addr_e3", imem_addr, 8'h02);
    chk("bp_ipc_e3", instr_pc, 8'h00);
    step();
    chk("bp_req_e4", imem_req, 0);
    chk("bp_valid_e4", instr_valid, 1);
    instr_ready = 1'b1;
    step();
    chk("bp_req_e5", imem_req, 1);
    chk("bp_addr_e5", imem_addr, 8'h02);
    chk("bp_ipc_e5", instr_pc, 8'h01);
    // slow memory: address holds for the whole wait, one push per ack
    imem_ack = 1'b0;
    do_reset();
    step();
    chk("sl_req_e1", imem_req, 1);
    step();
    chk("sl_addr_e2", imem_addr, 8'h00);
    chk("sl_valid_e2", instr_valid, 0);
    step();
    chk("sl_addr_e3", imem_addr, 8'h00);
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    chk("sl_addr_e4", imem_addr, 8'h01);
    chk("sl_valid_e4", instr_valid, 1);
    chk("sl_ipc_e4", instr_pc, 8'h00);
    step();
    chk("sl_valid_e5", instr_valid, 0);
    chk("sl_addr_e5", imem_addr, 8'h01);
    step();
    chk("sl_valid_e6", instr_valid, 0);
    // redirect while the 0x05 read is outstanding
    imem_ack = 1'b1;
    do_reset();
    repeat (6) step();
    chk("rd_addr_pre", imem_addr, 8'h05);
    imem_ack = 1'b0;
    redirect = 1'b1;
    redirect_pc = 8'h40;
    step();
    redirect = 1'b0;
    chk("rd_req_disc", imem_req, 1);
    chk("rd_addr_disc", imem_addr, 8'h05);
    chk("rd_valid_disc", instr_valid, 0);
    imem_ack = 1'b1;
    step();
    chk("rd_addr_new", imem_addr, 8'h40);
    chk("rd_valid_drop", instr_valid, 0);
    step();
    chk("rd_valid_40", instr_valid, 1);
    chk("rd_ipc_40", instr_pc, 8'h40);
    chk("rd_instr_40", instr, 16'hC040);
    chk("rd_addr_41", imem_addr, 8'h41);
    // redirect on the same edge as an ack and a pop
    redirect = 1'b1;
    redirect_pc = 8'h80;
    step();
    redirect = 1'b0;
    chk("rs_valid", instr_valid, 0);
    chk("rs_addr", imem_addr, 8'h80);
    chk("rs_req", imem_req, 1);
    step();
    chk("rs_ipc", instr_pc, 8'h80);
    chk("rs_valid2", instr_valid, 1);
    chk("rs_addr2", imem_addr, 8'h81);
    // PC wrap from 0xFF to 0x00
    redirect = 1'b1;
    redirect_pc = 8'hFE;
    step();
    redirect = 1'b0;
    chk("w_addr_fe", imem_addr, 8'hFE);
    step();
    chk("w_addr_ff", imem_addr, 8'hFF);
    chk("w_ipc_fe", instr_pc, 8'hFE);
    step();
    chk("w_addr_00", imem_addr, 8'h00);
    chk("w_ipc_ff", instr_pc, 8'hFF);
    step();
    chk("w_ipc_00", instr_pc, 8'h00);
    chk("w_addr_01", imem_addr, 8'h01);
    // asynchronous reset pulse mid-fetch
    #3;
    nReset = 1'b0;
    #1;
    check_reset("ar");
    @(negedge clk);
    nReset = 1'b1;
    step();
    chk("ar_req_e1", imem_req, 1);
    chk("ar_addr_e1", imem_addr, 8'h00);
    chk("ar_valid_e1", instr_valid, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
